// File: rtl/apb_ucpd_pkg.sv
// ---------------------------------------------------------------------------
// apb_ucpd_pkg
// Shared constants for the UCPD CC attach/detach logic: FSM state encoding
// (also exported through the status register), debounce-field widths and the
// microsecond-to-millisecond divider terminal count.
// ---------------------------------------------------------------------------
package apb_ucpd_pkg;

    // us ticks per ms, minus 1
    localparam int MS_CNT_MAX  = 999;
    // depth of the CC comparator synchronisers
    localparam int SYNC_STAGES = 2;

    localparam int FREQ_W    = 6;   // clk_freq field (MHz)
    localparam int T_CCDEB_W = 8;   // attach debounce field (ms)
    localparam int T_PDDEB_W = 5;   // detach debounce field (ms)
    localparam int MS_CNT_W  = 8;   // elapsed-ms counter
    localparam int STATE_W   = 3;   // fsm_state status field

    typedef enum logic [STATE_W-1:0] {
        CC_IDLE     = 3'd0,
        CC_UNATT    = 3'd1,
        CC_ATT_WAIT = 3'd2,
        CC_ATTACHED = 3'd3,
        CC_DET_WAIT = 3'd4
    } cc_state_e;

    // Last us_cnt value of a microsecond: a 0 MHz setting behaves as 1 MHz.
    function automatic logic [FREQ_W-1:0] us_last(input logic [FREQ_W-1:0] freq);
        if (freq == {FREQ_W{1'b0}}) begin
            us_last = {FREQ_W{1'b0}};
        end else begin
            us_last = freq - 1'b1;
        end
    endfunction

endpackage

// File: rtl/apb_ucpd_tick_gen.sv
// ---------------------------------------------------------------------------
// apb_ucpd_tick_gen
// Restartable microsecond / millisecond timebase for UCPD timers.
//   ic_clk, ic_rst_n : clock, asynchronous active-low reset
//   clk_freq         : ic_clk frequency in MHz (0 treated as 1), sampled live
//   clr              : synchronous restart of both dividers; a window timed
//                      from clr is therefore exact to within one cycle
//   us_tick          : registered one-cycle pulse every max(clk_freq,1) cycles
//   ms_tick          : registered one-cycle pulse every MS_MAX+1 us ticks,
//                      always coincident with a us_tick
// ---------------------------------------------------------------------------
module apb_ucpd_tick_gen
    import apb_ucpd_pkg::*;
#(
    parameter int MS_MAX = MS_CNT_MAX
) (
    input  logic              ic_clk,
    input  logic              ic_rst_n,
    input  logic [FREQ_W-1:0] clk_freq,
    input  logic              clr,
    output logic              us_tick,
    output logic              ms_tick
);

    localparam int SUB_W = $clog2(MS_MAX + 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(MS_MAX);

    logic [FREQ_W-1:0] us_cnt_r;
    logic [SUB_W-1:0]  sub_cnt_r;
    logic              us_tick_r;
    logic              ms_tick_r;
    logic              us_wrap_s;
    logic              ms_wrap_s;

    // Divider terminal-count decode; >= lets a live clk_freq decrease wrap at once
    always_comb begin
        us_wrap_s = (us_cnt_r >= us_last(clk_freq));
        ms_wrap_s = us_wrap_s && (sub_cnt_r >= SUB_LAST);
    end

    // Cascaded us / ms dividers with registered tick outputs
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            us_cnt_r  <= {FREQ_W{1'b0}};
            sub_cnt_r <= {SUB_W{1'b0}};
            us_tick_r <= 1'b0;
            ms_tick_r <= 1'b0;
        end else if (clr) begin
            us_cnt_r  <= {FREQ_W{1'b0}};
            sub_cnt_r <= {SUB_W{1'b0}};
            us_tick_r <= 1'b0;
            ms_tick_r <= 1'b0;
        end else begin
            us_tick_r <= us_wrap_s;
            ms_tick_r <= ms_wrap_s;
            if (us_wrap_s) begin
                us_cnt_r <= {FREQ_W{1'b0}};
                if (ms_wrap_s) begin
                    sub_cnt_r <= {SUB_W{1'b0}};
                end else begin
                    sub_cnt_r <= sub_cnt_r + 1'b1;
                end
            end else begin
                us_cnt_r  <= us_cnt_r + 1'b1;
                sub_cnt_r <= sub_cnt_r;
            end
        end
    end

    assign us_tick = us_tick_r;
    assign ms_tick = ms_tick_r;

endmodule

// File: rtl/apb_ucpd_cc_attach_ctrl.sv
// ---------------------------------------------------------------------------
// apb_ucpd_cc_attach_ctrl
// Type-C attach/detach sequencer. Synchronises the CC1/CC2 comparator levels,
// debounces attach (tCCDebounce) and detach (tPDDebounce) with one shared,
// restartable ms timebase, and reports the result to the register block.
//   ic_clk, ic_rst_n : clock, asynchronous active-low reset
//   clk_freq         : ic_clk frequency in MHz (0 treated as 1)
//   cc_det_en        : detection enable; low forces IDLE
//   cc1_in, cc2_in   : raw asynchronous comparator levels (1 = Rd/Rp seen)
//   t_ccdeb_ms       : attach debounce (ms), sampled live
//   t_pddeb_ms       : detach debounce (ms), sampled live
//   attached         : registered; high in ATTACHED / DET_WAIT
//   orient           : registered; 0 = CC1 active, 1 = CC2 active
//   cc_evt           : registered one-cycle pulse on every attached change
//   fsm_state        : current state encoding
// ---------------------------------------------------------------------------
module apb_ucpd_cc_attach_ctrl
    import apb_ucpd_pkg::*;
#(
    parameter int MS_CNT_MAX  = apb_ucpd_pkg::MS_CNT_MAX,
    parameter int SYNC_STAGES = apb_ucpd_pkg::SYNC_STAGES
) (
    input  logic                 ic_clk,
    input  logic                 ic_rst_n,
    input  logic [FREQ_W-1:0]    clk_freq,
    input  logic                 cc_det_en,
    input  logic                 cc1_in,
    input  logic                 cc2_in,
    input  logic [T_CCDEB_W-1:0] t_ccdeb_ms,
    input  logic [T_PDDEB_W-1:0] t_pddeb_ms,
    output logic                 attached,
    output logic                 orient,
    output logic                 cc_evt,
    output logic [STATE_W-1:0]   fsm_state
);

    logic [SYNC_STAGES-1:0] cc1_sync_r;
    logic [SYNC_STAGES-1:0] cc2_sync_r;
    logic                   cc1_s;
    logic                   cc2_s;

    cc_state_e              state_r;
    logic                   attached_r;
    logic                   orient_r;
    logic                   cc_evt_r;
    logic                   cand_r;
    logic [MS_CNT_W-1:0]    ms_cnt_r;

    logic                   us_tick_s;
    logic                   ms_tick_s;
    logic                   clr_s;
    logic                   one_hot_s;
    logic                   active_s;
    logic                   pattern_ok_s;
    logic                   att_done_s;
    logic                   det_done_s;

    // Two-flop (SYNC_STAGES) synchronisers for the asynchronous CC levels
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            cc1_sync_r <= {SYNC_STAGES{1'b0}};
            cc2_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            cc1_sync_r <= {cc1_sync_r[SYNC_STAGES-2:0], cc1_in};
            cc2_sync_r <= {cc2_sync_r[SYNC_STAGES-2:0], cc2_in};
        end
    end

    assign cc1_s = cc1_sync_r[SYNC_STAGES-1];
    assign cc2_s = cc2_sync_r[SYNC_STAGES-1];

    apb_ucpd_tick_gen #(
        .MS_MAX   (MS_CNT_MAX)
    ) u_tick_gen (
        .ic_clk   (ic_clk),
        .ic_rst_n (ic_rst_n),
        .clk_freq (clk_freq),
        .clr      (clr_s),
        .us_tick  (us_tick_s),
        .ms_tick  (ms_tick_s)
    );

    // Line decodes and the wait-state-entry restart of the timebase
    always_comb begin
        one_hot_s    = cc1_s ^ cc2_s;
        // only the line selected by orientation matters once attached
        active_s     = orient_r ? cc2_s : cc1_s;
        // candidate pattern is fully determined by which single line was high
        pattern_ok_s = ({cc1_s, cc2_s} == {~cand_r, cand_r});
        att_done_s   = (ms_cnt_r >= t_ccdeb_ms);
        det_done_s   = (ms_cnt_r >= {3'b000, t_pddeb_ms});
        clr_s        = 1'b0;
        if (cc_det_en) begin
            case (state_r)
                CC_UNATT:    clr_s = one_hot_s;
                CC_ATTACHED: clr_s = ~active_s;
                default:     clr_s = 1'b0;
            endcase
        end else begin
            clr_s = 1'b0;
        end
    end

    // Elapsed-ms counter: restarted with the timebase, saturates at 255
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            ms_cnt_r <= {MS_CNT_W{1'b0}};
        end else if (clr_s) begin
            ms_cnt_r <= {MS_CNT_W{1'b0}};
        end else if (ms_tick_s && us_tick_s && (ms_cnt_r != 8'hFF)) begin
            ms_cnt_r <= ms_cnt_r + 1'b1;
        end else begin
            ms_cnt_r <= ms_cnt_r;
        end
    end

    // Attach/detach FSM with registered status outputs
    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state_r    <= CC_IDLE;
            attached_r <= 1'b0;
            orient_r   <= 1'b0;
            cc_evt_r   <= 1'b0;
            cand_r     <= 1'b0;
        end else begin
            cc_evt_r <= 1'b0;
            if (!cc_det_en) begin
                // disabling while attached is reported as a detach
                state_r    <= CC_IDLE;
                attached_r <= 1'b0;
                cc_evt_r   <= attached_r;
            end else begin
                case (state_r)
                    CC_IDLE: begin
                        state_r <= CC_UNATT;
                    end
                    CC_UNATT: begin
                        // both lines high (debug accessory) is deliberately ignored
                        if (one_hot_s) begin
                            state_r <= CC_ATT_WAIT;
                            cand_r  <= cc2_s;
                        end
                    end
                    CC_ATT_WAIT: begin
                        // a pattern change beats a simultaneous timeout
                        if (!pattern_ok_s) begin
                            state_r <= CC_UNATT;
                        end else if (att_done_s) begin
                            state_r    <= CC_ATTACHED;
                            attached_r <= 1'b1;
                            orient_r   <= cand_r;
                            cc_evt_r   <= 1'b1;
                        end
                    end
                    CC_ATTACHED: begin
                        if (!active_s) begin
                            state_r <= CC_DET_WAIT;
                        end
                    end
                    CC_DET_WAIT: begin
                        // a returning line beats a simultaneous timeout
                        if (active_s) begin
                            state_r <= CC_ATTACHED;
                        end else if (det_done_s) begin
                            state_r    <= CC_UNATT;
                            attached_r <= 1'b0;
                            cc_evt_r   <= 1'b1;
                        end
                    end
                    default: begin
                        state_r    <= CC_IDLE;
                        attached_r <= 1'b0;
                        cc_evt_r   <= attached_r;
                    end
                endcase
            end
        end
    end

    assign attached  = attached_r;
    assign orient    = orient_r;
    assign cc_evt    = cc_evt_r;
    assign fsm_state = state_r;

endmodule

// File: tb/tb_apb_ucpd_cc_attach_ctrl.sv
module tb_apb_ucpd_cc_attach_ctrl;

    logic       ic_clk = 1'b0;
    logic       ic_rst_n;
    logic [5:0] clk_freq;
    logic       cc_det_en;
    logic       cc1_in;
    logic       cc2_in;
    logic [7:0] t_ccdeb_ms;
    logic [4:0] t_pddeb_ms;
    logic       attached;
    logic       orient;
    logic       cc_evt;
    logic [2:0] fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    int evt_total = 0;

    // reference model state (spec state numbers, time measured in edges)
    int   m_st, m_n;
    logic m_att, m_or, m_evt, m_cand;
    logic [1:0] h1, h2;

    typedef struct {
        logic       en;
        logic       cc1;
        logic       cc2;
        logic [7:0] tcc;
        logic [4:0] tpd;
        int         ncyc;
        int         st;
        int         att;
        int         ori;
        int         evts;
    } vec_t;

    vec_t vecs[$];

    always #5 ic_clk = ~ic_clk;

    apb_ucpd_cc_attach_ctrl dut (
        .ic_clk     (ic_clk),
        .ic_rst_n   (ic_rst_n),
        .clk_freq   (clk_freq),
        .cc_det_en  (cc_det_en),
        .cc1_in     (cc1_in),
        .cc2_in     (cc2_in),
        .t_ccdeb_ms (t_ccdeb_ms),
        .t_pddeb_ms (t_pddeb_ms),
        .attached   (attached),
        .orient     (orient),
        .cc_evt     (cc_evt),
        .fsm_state  (fsm_state)
    );

    task automatic cyc();
        @(negedge ic_clk);
        if (cc_evt) evt_total++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_state(input string name, input int st, input int budget, output int n);
        n = 0;
        while (int'(fsm_state) != st && n < budget) begin
            cyc();
            n++;
        end
        check(name, int'(fsm_state), st);
    endtask

    task automatic wait_att(input string name, input logic val, input int budget, output int n);
        n = 0;
        while (attached !== val && n < budget) begin
            cyc();
            n++;
        end
        check(name, int'(attached), int'(val));
    endtask

    task automatic do_reset();
        ic_rst_n  = 1'b0;
        cc_det_en = 1'b0;
        cc1_in    = 1'b0;
        cc2_in    = 1'b0;
        run(3);
        ic_rst_n = 1'b1;
        cyc();
    endtask

    function automatic vec_t mk(input logic en, input logic cc1, input logic cc2,
                                input int tcc, input int tpd, input int ncyc,
                                input int st, input int att, input int ori, input int evts);
        vec_t v;
        v.en = en; v.cc1 = cc1; v.cc2 = cc2;
        v.tcc = 8'(tcc); v.tpd = 5'(tpd); v.ncyc = ncyc;
        v.st = st; v.att = att; v.ori = ori; v.evts = evts;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_n = 0; m_att = 1'b0; m_or = 1'b0; m_evt = 1'b0; m_cand = 1'b0;
        h1 = 2'b00; h2 = 2'b00;
    endtask

    // One clock edge of the reference: levels seen two edges late, elapsed ms
    // computed directly from edges since window entry.
    task automatic model_step();
        logic [1:0] s;
        logic       act;
        int         dv, ms;
        s  = h2;
        h2 = h1;
        h1 = {cc1_in, cc2_in};
        dv = (clk_freq == 6'd0) ? 1 : int'(clk_freq);
        ms = (m_n == 0) ? 0 : (m_n - 1) / (1000 * dv);
        if (ms > 255) ms = 255;
        m_n++;
        m_evt = 1'b0;
        act = m_or ? s[0] : s[1];
        if (!cc_det_en) begin
            m_evt = m_att;
            m_att = 1'b0;
            m_st  = 0;
        end else begin
            case (m_st)
                0: m_st = 1;
                1: if (s == 2'b10 || s == 2'b01) begin
                       m_st = 2; m_cand = s[0]; m_n = 0;
                   end
                2: if (s != {~m_cand, m_cand}) m_st = 1;
                   else if (ms >= int'(t_ccdeb_ms)) begin
                       m_st = 3; m_att = 1'b1; m_or = m_cand; m_evt = 1'b1;
                   end
                3: if (!act) begin m_st = 4; m_n = 0; end
                4: if (act) m_st = 3;
                   else if (ms >= int'(t_pddeb_ms)) begin
                       m_st = 1; m_att = 1'b0; m_evt = 1'b1;
                   end
                default: m_st = 0;
            endcase
        end
    endtask

    initial begin
        int n, ev0, nrf;
        logic [5:0] dut_v, mdl_v;

        ic_rst_n = 1'b0; clk_freq = 6'd0; cc_det_en = 1'b0;
        cc1_in = 1'b0; cc2_in = 1'b0; t_ccdeb_ms = 8'd1; t_pddeb_ms = 5'd2;
        run(2);
        check("rst attached", int'(attached), 0);
        check("rst orient", int'(orient), 0);
        check("rst cc_evt", int'(cc_evt), 0);
        check("rst state", int'(fsm_state), 0);

        // ---------------- table-driven vectors, clk_freq=0 (1 ms = 1000 cycles)
        vecs.push_back(mk(0, 0, 0, 1, 2,    5, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2,    5, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 2,   50, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 2,   10, 2, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 2, 1000, 3, 1, 0, 1));
        vecs.push_back(mk(1, 1, 1, 1, 2,   20, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 2,   10, 4, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 2,   10, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 2, 2100, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 2,   10, 3, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 2,    3, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 5, 2,   10, 2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 5, 2,   10, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,   10, 3, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,   10, 1, 0, 0, 1));
        do_reset();
        clk_freq = 6'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            cc_det_en = vecs[i].en; cc1_in = vecs[i].cc1; cc2_in = vecs[i].cc2;
            t_ccdeb_ms = vecs[i].tcc; t_pddeb_ms = vecs[i].tpd;
            ev0 = evt_total;
            run(vecs[i].ncyc);
            check($sformatf("vec%0d state", i), int'(fsm_state), vecs[i].st);
            check($sformatf("vec%0d attached", i), int'(attached), vecs[i].att);
            check($sformatf("vec%0d orient", i), int'(orient), vecs[i].ori);
            check($sformatf("vec%0d events", i), evt_total - ev0, vecs[i].evts);
        end

        // ---------------- 1: attach on CC1, clk_freq=4, 3 ms
        do_reset();
        clk_freq = 6'd4; t_ccdeb_ms = 8'd3; t_pddeb_ms = 5'd15;
        cc_det_en = 1'b1; cc1_in = 1'b1;
        wait_state("t1 att_wait", 2, 20, n);
        ev0 = evt_total;
        wait_att("t1 attach", 1'b1, 13000, n);
        check_range("t1 attach time", n, 11996, 12004);
        check("t1 orient", int'(orient), 0);
        run(5);
        check("t1 events", evt_total - ev0, 1);

        // ---------------- 2: attach on CC2, short and long drop
        do_reset();
        t_ccdeb_ms = 8'd2; t_pddeb_ms = 5'd5;
        cc_det_en = 1'b1; cc2_in = 1'b1;
        wait_att("t2 attach", 1'b1, 9000, n);
        check("t2 orient", int'(orient), 1);
        ev0 = evt_total;
        cc2_in = 1'b0;
        run(4000);
        check("t2 det_wait", int'(fsm_state), 4);
        cc2_in = 1'b1;
        run(10);
        check("t2 back attached", int'(fsm_state), 3);
        check("t2 no event", evt_total - ev0, 0);
        cc2_in = 1'b0;
        wait_state("t2 det_wait2", 4, 10, n);
        wait_att("t2 detach", 1'b0, 21000, n);
        check_range("t2 detach time", n, 19996, 20004);
        run(5);
        check("t2 detach events", evt_total - ev0, 1);
        check("t2 state unatt", int'(fsm_state), 1);
        check("t2 orient holds", int'(orient), 1);

        // ---------------- 3: 1 ms glitch on CC1
        t_ccdeb_ms = 8'd3;
        ev0 = evt_total;
        cc1_in = 1'b1;
        wait_state("t3 att_wait", 2, 10, n);
        run(3990);
        check("t3 still waiting", int'(fsm_state), 2);
        cc1_in = 1'b0;
        run(10);
        check("t3 unatt", int'(fsm_state), 1);
        check("t3 attached", int'(attached), 0);
        check("t3 events", evt_total - ev0, 0);

        // ---------------- 4: both lines high
        cc1_in = 1'b1; cc2_in = 1'b1;
        nrf = 0;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (fsm_state != 3'd1) nrf++;
        end
        check("t4 cycles not unatt", nrf, 0);
        cc2_in = 1'b0;
        wait_state("t4 att_wait", 2, 10, n);
        check_range("t4 entry latency", n, 2, 3);

        // ---------------- 5: disable while attached, reset mid-window
        do_reset();
        clk_freq = 6'd0; t_ccdeb_ms = 8'd0;
        cc_det_en = 1'b1; cc1_in = 1'b1;
        wait_att("t5 attach", 1'b1, 20, n);
        ev0 = evt_total;
        cc_det_en = 1'b0;
        cyc();
        check("t5 idle", int'(fsm_state), 0);
        check("t5 attached", int'(attached), 0);
        run(10);
        check("t5 events", evt_total - ev0, 1);
        t_ccdeb_ms = 8'd3; cc_det_en = 1'b1;
        wait_state("t5 att_wait", 2, 10, n);
        ev0 = evt_total;
        #3 ic_rst_n = 1'b0;
        #1;
        check("t5 rst state", int'(fsm_state), 0);
        check("t5 rst attached", int'(attached), 0);
        check("t5 rst orient", int'(orient), 0);
        check("t5 rst cc_evt", int'(cc_evt), 0);
        run(3);
        ic_rst_n = 1'b1;
        run(3);
        check("t5 rst events", evt_total - ev0, 0);

        // ---------------- 6: zero debounce, clk_freq=0 timing, live config
        do_reset();
        clk_freq = 6'd0; t_ccdeb_ms = 8'd0;
        cc_det_en = 1'b1; cc1_in = 1'b1;
        wait_state("t6 att_wait", 2, 10, n);
        cyc();
        check("t6 zero deb state", int'(fsm_state), 3);
        cc_det_en = 1'b0; cyc();
        t_ccdeb_ms = 8'd1; cc_det_en = 1'b1;
        wait_state("t6 att_wait2", 2, 10, n);
        wait_att("t6 attach", 1'b1, 1100, n);
        check_range("t6 1ms at clk_freq0", n, 998, 1004);
        cc_det_en = 1'b0; cyc();
        t_ccdeb_ms = 8'd5; cc_det_en = 1'b1;
        wait_state("t6 att_wait3", 2, 10, n);
        run(2100);
        check("t6 mid window", int'(attached), 0);
        t_ccdeb_ms = 8'd1;
        cyc();
        check("t6 lowered threshold", int'(attached), 1);

        // ---------------- randomized run against the reference model
        do_reset();
        model_reset();
        for (int seg = 0; seg < 4; seg++) begin
            clk_freq = 6'(seg % 3);
            for (int i = 0; i < 4000; i++) begin
                cc_det_en = (i < 5) ? 1'b0 : ($urandom_range(0, 1999) != 0);
                if ($urandom_range(0, 2499) == 0) cc1_in = ~cc1_in;
                if ($urandom_range(0, 2499) == 0) cc2_in = ~cc2_in;
                if ($urandom_range(0, 299) == 0) cc1_in = ~cc1_in;
                if ($urandom_range(0, 999) == 0) t_ccdeb_ms = 8'($urandom_range(0, 1));
                if ($urandom_range(0, 999) == 0) t_pddeb_ms = 5'($urandom_range(0, 1));
                model_step();
                cyc();
                dut_v = {fsm_state, attached, orient, cc_evt};
                mdl_v = {3'(m_st), m_att, m_or, m_evt};
                n_tests++;
                if (dut_v !== mdl_v) begin
                    n_fail++;
                    if (n_fail < 20)
                        $display("FAIL rand seg%0d cyc%0d {state,att,ori,evt}: got %b, expected %b",
                                 seg, i, dut_v, mdl_v);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
